// File: rtl/aes_dec_core_debug_ocimem_ctrl_pkg.sv
// Shared types for the debug-RAM controller: FSM states, command ops, jdo field positions.
package aes_dec_debug_pkg;

    typedef enum logic [1:0] {IDLE, J_REQ, J_VFY, J_RSP} state_e;

    // OP_LOAD is the ocimem_a read: same access as OP_RD but no post-increment.
    typedef enum logic [1:0] {OP_LOAD, OP_WR, OP_RD} op_e;

    localparam int ADDR_LSB   = 26;
    localparam int RDFLAG_BIT = 25;
    localparam int WDATA_LSB  = 3;

endpackage

// File: rtl/aes_dec_core_debug_ocimem_ctrl_if.sv
// CPU-side Avalon debug-memory slave bus; master = CPU, slave = controller.
interface aes_dec_core_debug_ocimem_ctrl_if #(parameter int ADDR_W = 8);

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_waitrequest;
    logic [31:0]       avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata
    );

endinterface

// File: rtl/aes_dec_core_debug_ocimem_ctrl_ociram.sv
// Single-port 32-bit synchronous debug RAM with byte enables; q holds the last read word.
module aes_dec_core_debug_ociram #(
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = "UNUSED"
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       q_o
);

    // Image loading is handled by the memory-compiler flow; the name is only carried here.
    localparam bit unused_init = (INIT_FILE == "UNUSED");

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] q_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                q_q <= mem[addr_i];
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/aes_dec_core_debug_ocimem_ctrl.sv
// JTAG ocimem command engine sharing the debug RAM with the CPU slave port.
// Optional: OCIMEM_WRITE_READBACK_EN adds a J_VFY re-read after JTAG writes.
import aes_dec_debug_pkg::*;

module aes_dec_core_debug_ocimem_ctrl #(
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = "UNUSED"
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [37:0]                        jdo,
    input  logic                               take_action_ocimem_a,
    input  logic                               take_action_ocimem_b,
    input  logic                               take_no_action_ocimem_a,
    aes_dec_core_debug_ocimem_ctrl_if.slave    avs,
    output logic [31:0]                        MonDReg,
    output logic                               monitor_ready,
    output logic                               monitor_error,
    output logic                               jtag_busy
);

    logic [ADDR_W-1:0] jdo_addr_d;
    logic              jdo_rd_d;
    logic [31:0]       jdo_wdata_d;
    logic [1:0]        n_strobe_d;
    logic              any_strobe_d;
    logic              multi_strobe_d;
    logic              unused_jdo;

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] acc_addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mon_q;
    logic              ready_q;
    logic              error_q;

    logic              jtag_owns_d;
    logic              ram_en_d;
    logic              ram_we_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [3:0]        ram_be_d;
    logic [31:0]       ram_wdata_d;
    logic [31:0]       ram_q;

    assign jdo_addr_d  = jdo[ADDR_LSB +: ADDR_W];
    assign jdo_rd_d    = jdo[RDFLAG_BIT];
    assign jdo_wdata_d = jdo[WDATA_LSB +: 32];
    assign unused_jdo  = ^{jdo[37:35], jdo[2:0]};

    assign n_strobe_d     = {1'b0, take_action_ocimem_a} + {1'b0, take_action_ocimem_b}
                          + {1'b0, take_no_action_ocimem_a};
    assign any_strobe_d   = (n_strobe_d != 2'd0);
    assign multi_strobe_d = (n_strobe_d > 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_LOAD;
            addr_q     <= '0;
            acc_addr_q <= '0;
            wdata_q    <= '0;
            mon_q      <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // Colliding strobes are flagged and dropped; the in-flight op is untouched.
            if (multi_strobe_d || (any_strobe_d && state_q != IDLE)) error_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (any_strobe_d && !multi_strobe_d) begin
                        wdata_q <= jdo_wdata_d;
                        if (take_action_ocimem_a) begin
                            addr_q     <= jdo_addr_d;
                            acc_addr_q <= jdo_addr_d;
                            op_q       <= OP_LOAD;
                            error_q    <= 1'b0;
                            if (jdo_rd_d) begin
                                ready_q <= 1'b0;
                                state_q <= J_REQ;
                            end else begin
                                ready_q <= 1'b1;
                            end
                        end else begin
                            acc_addr_q <= addr_q;
                            op_q       <= take_action_ocimem_b ? OP_WR : OP_RD;
                            ready_q    <= 1'b0;
                            state_q    <= J_REQ;
                        end
                    end
                end
                J_REQ: begin
                    if (op_q != OP_LOAD) addr_q <= acc_addr_q + 1'b1;
`ifdef OCIMEM_WRITE_READBACK_EN
                    state_q <= (op_q == OP_WR) ? J_VFY : J_RSP;
`else
                    state_q <= J_RSP;
`endif
                end
`ifdef OCIMEM_WRITE_READBACK_EN
                J_VFY: state_q <= J_RSP;
`endif
                J_RSP: begin
`ifdef OCIMEM_WRITE_READBACK_EN
                    mon_q <= ram_q;
`else
                    if (op_q != OP_WR) mon_q <= ram_q;
`endif
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // JTAG owns the RAM in J_REQ (and J_VFY); everywhere else the CPU port drives it.
    assign jtag_owns_d = (state_q == J_REQ) || (state_q == J_VFY);

    always_comb begin
        ram_en_d    = avs.avs_read | avs.avs_write;
        ram_we_d    = avs.avs_write;
        ram_addr_d  = avs.avs_address;
        ram_be_d    = avs.avs_byteenable;
        ram_wdata_d = avs.avs_writedata;
        if (jtag_owns_d) begin
            ram_en_d    = 1'b1;
            ram_we_d    = (state_q == J_REQ) && (op_q == OP_WR);
            ram_addr_d  = acc_addr_q;
            ram_be_d    = 4'hF;
            ram_wdata_d = wdata_q;
        end
    end

    aes_dec_core_debug_ociram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ociram (
        .clk     (clk),
        .en_i    (ram_en_d),
        .we_i    (ram_we_d),
        .addr_i  (ram_addr_d),
        .be_i    (ram_be_d),
        .wdata_i (ram_wdata_d),
        .q_o     (ram_q)
    );

    assign avs.avs_waitrequest = jtag_owns_d;
    assign avs.avs_readdata    = ram_q;
    assign MonDReg             = mon_q;
    assign monitor_ready       = ready_q;
    assign monitor_error       = error_q;
    assign jtag_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_aes_dec_core_debug_ocimem_ctrl.sv
// Directed bench for the JTAG/CPU debug-RAM controller (ADDR_W=8).
module tb_aes_dec_core_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        act_a, act_b, noact_a;
    logic [31:0] mon;
    logic        ready, err, busy;
    int          errors = 0;
    int          checks = 0;

    aes_dec_core_debug_ocimem_ctrl_if #(.ADDR_W(8)) avs_if ();

    aes_dec_core_debug_ocimem_ctrl #(.ADDR_W(8), .INIT_FILE("UNUSED")) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (act_a),
        .take_action_ocimem_b    (act_b),
        .take_no_action_ocimem_a (noact_a),
        .avs                     (avs_if.slave),
        .MonDReg                 (mon),
        .monitor_ready           (ready),
        .monitor_error           (err),
        .jtag_busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[33:26] = a;
        j[25]    = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] wd);
        logic [37:0] j;
        j = '0;
        j[34:3] = wd;
        return j;
    endfunction

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_if.avs_address    = a;
        avs_if.avs_writedata  = d;
        avs_if.avs_byteenable = be;
        avs_if.avs_write      = 1'b1;
        tick();
        avs_if.avs_write      = 1'b0;
    endtask

    task automatic cpu_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        avs_if.avs_address = a;
        avs_if.avs_read    = 1'b1;
        tick();
        avs_if.avs_read    = 1'b0;
        chk(tag, avs_if.avs_readdata, exp);
    endtask

    // Drive one strobe set for a single cycle; returns in the cycle after the strobe.
    task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] j);
        jdo = j; act_a = a; act_b = b; noact_a = n;
        tick();
        act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0; act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0;
        avs_if.avs_address = '0; avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
        avs_if.avs_writedata = '0; avs_if.avs_byteenable = 4'hF;
        tick(); tick();
        chk("rst_mondreg", mon, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_error", {31'b0, err}, 32'h0);
        chk("rst_waitreq", {31'b0, avs_if.avs_waitrequest}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        tick();

        cpu_wr(8'h10, 32'hDEADBEEF, 4'hF);
        cpu_wr(8'h11, 32'hCAFEF00D, 4'hF);
        cpu_wr(8'h12, 32'h55667788, 4'hF);
        cpu_wr(8'h20, 32'hA5A55A5A, 4'hF);
        cpu_wr(8'hFF, 32'h0BADF00D, 4'hF);
        cpu_wr(8'h00, 32'h11112222, 4'hF);

        // Load + read of 0x10
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
        chk("ld_jreq_busy", {31'b0, busy}, 32'h1);
        chk("ld_jreq_waitreq", {31'b0, avs_if.avs_waitrequest}, 32'h1);
        chk("ld_jreq_ready", {31'b0, ready}, 32'h0);
        tick();
        chk("ld_jrsp_waitreq", {31'b0, avs_if.avs_waitrequest}, 32'h0);
        tick();
        chk("ld_mondreg", mon, 32'hDEADBEEF);
        chk("ld_ready", {31'b0, ready}, 32'h1);
        chk("ld_idle", {31'b0, busy}, 32'h0);

        // Write at 0x10, then post-incremented reads 0x11, 0x12
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
        chk("wr_jreq_ready", {31'b0, ready}, 32'h0);
        tick(); tick();
        chk("wr_ready", {31'b0, ready}, 32'h1);
        chk("wr_mondreg_kept", mon, 32'hDEADBEEF);
        cpu_rd("wr_ram10", 8'h10, 32'h12345678);
        strobe(1'b0, 1'b0, 1'b1, '0);
        tick(); tick();
        chk("rd_inc_11", mon, 32'hCAFEF00D);
        strobe(1'b0, 1'b0, 1'b1, '0);
        tick(); tick();
        chk("rd_inc_12", mon, 32'h55667788);

        // Address-only load at 0xFF, then reads wrap to 0x00
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0));
        chk("ldonly_ready", {31'b0, ready}, 32'h1);
        chk("ldonly_busy", {31'b0, busy}, 32'h0);
        strobe(1'b0, 1'b0, 1'b1, '0);
        tick(); tick();
        chk("wrap_ff", mon, 32'h0BADF00D);
        strobe(1'b0, 1'b0, 1'b1, '0);
        tick(); tick();
        chk("wrap_00", mon, 32'h11112222);

        // CPU read of 0x20 held across a JTAG read of 0x10
        avs_if.avs_address = 8'h20;
        avs_if.avs_read    = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
        chk("arb_rd1", avs_if.avs_readdata, 32'hA5A55A5A);
        chk("arb_wait_jreq", {31'b0, avs_if.avs_waitrequest}, 32'h1);
        tick();
        chk("arb_wait_jrsp", {31'b0, avs_if.avs_waitrequest}, 32'h0);
        tick();
        avs_if.avs_read = 1'b0;
        chk("arb_rd2", avs_if.avs_readdata, 32'hA5A55A5A);
        chk("arb_mondreg", mon, 32'h12345678);

        // Two strobes in one cycle
        strobe(1'b0, 1'b1, 1'b1, jdo_b(32'hFFFFFFFF));
        chk("col_same_err", {31'b0, err}, 32'h1);
        chk("col_same_busy", {31'b0, busy}, 32'h0);
        cpu_rd("col_same_ram", 8'h10, 32'h12345678);

        // ocimem_a clears the error; a strobe during J_REQ sets it again
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h20, 1'b1));
        chk("col_clear", {31'b0, err}, 32'h0);
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'hFFFFFFFF));
        chk("col_jreq_err", {31'b0, err}, 32'h1);
        tick();
        chk("col_inflight", mon, 32'hA5A55A5A);
        chk("col_inflight_rdy", {31'b0, ready}, 32'h1);
        cpu_rd("col_jreq_ram10", 8'h10, 32'h12345678);
        cpu_rd("col_jreq_ram20", 8'h20, 32'hA5A55A5A);

        // Byte enables, and read+write together
        cpu_wr(8'h20, 32'h0000BEEF, 4'b0011);
        cpu_rd("cpu_be", 8'h20, 32'hA5A5BEEF);
        avs_if.avs_read = 1'b1;
        cpu_wr(8'h21, 32'h77777777, 4'hF);
        avs_if.avs_read = 1'b0;
        cpu_rd("cpu_rw_wins", 8'h21, 32'h77777777);

        // Reset during J_RSP of a read
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rsp_rst_mondreg", mon, 32'h0);
        chk("rsp_rst_ready", {31'b0, ready}, 32'h0);
        chk("rsp_rst_error", {31'b0, err}, 32'h0);
        chk("rsp_rst_busy", {31'b0, busy}, 32'h0);
        chk("rsp_rst_waitreq", {31'b0, avs_if.avs_waitrequest}, 32'h0);

        // Reset during J_REQ of a write: the write still lands at address 0
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h0F0F0F0F));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("req_rst_busy", {31'b0, busy}, 32'h0);
        cpu_rd("req_rst_ram0", 8'h00, 32'h0F0F0F0F);
        strobe(1'b0, 1'b0, 1'b1, '0);
        tick(); tick();
        chk("req_rst_addr0", mon, 32'h0F0F0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
